// File: rtl/aes_inv_round_ctrl_if.sv
// Block and round-key handshake bundle for the iterative AES-128 decrypt controller.
// Slave is the controller; master is the host plus key-schedule memory.
interface aes_inv_round_ctrl_if;
  logic         in_valid;
  logic         in_ready;
  logic [0:127] in_data;
  logic [3:0]   rk_idx;
  logic [0:127] rk_data;
  logic         out_valid;
  logic         out_ready;
  logic [0:127] out_data;
  logic         busy;

  modport slave (
    input  in_valid, in_data, rk_data, out_ready,
    output in_ready, rk_idx, out_valid, out_data, busy
  );

  modport master (
    output in_valid, in_data, rk_data, out_ready,
    input  in_ready, rk_idx, out_valid, out_data, busy
  );
endinterface

// File: rtl/aes_inv_round_ctrl.sv
// Iterative AES-128 decrypt: one inverse round per clock, 10 cycles accept-to-out_valid.
// in_ready only in IDLE; result held in DONE until out_ready (12-cycle minimum block period).
module inv_shift_rows (
  input  logic [0:127] d,
  output logic [0:127] q
);
  // Row r rotates right by r: output column c takes input column (c - r) mod 4.
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign q[8*(4*c+r) +: 8] = d[8*(4*((c+4-r)%4)+r) +: 8];
    end
  end
endmodule

module aes_inv_round_ctrl #(
  parameter int NR = 10
) (
  input logic             clk,
  input logic             rst_n,
  aes_inv_round_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (a^2 * a^4 * ... * a^128); maps 0 to 0.
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] r;
    sq = a;
    r  = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gmul(sq, sq);
      r  = gmul(r, sq);
    end
    return r;
  endfunction

  // Undo the forward affine map, then invert in GF(2^8).
  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    logic [7:0] x;
    x = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
    return ginv(x);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] a);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = a;
    return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
            gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
            gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
            gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
  endfunction

  state_t       state_q, state_d;
  logic [0:127] st_q, st_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [3:0]   rk_idx_q, rk_idx_d;
  logic         in_ready_q, in_ready_d;
  logic         out_valid_q, out_valid_d;
  logic         busy_q, busy_d;

  logic [0:127] sr;
  logic [0:127] t;
  logic [0:127] mixed;

  inv_shift_rows u_isr (
    .d (st_q),
    .q (sr)
  );

  always_comb begin
    t     = '0;
    mixed = '0;
    for (int i = 0; i < 16; i++) begin
      t[8*i +: 8] = inv_sbox(sr[8*i +: 8]) ^ bus.rk_data[8*i +: 8];
    end
    for (int c = 0; c < 4; c++) begin
      mixed[32*c +: 32] = inv_mix_col(t[32*c +: 32]);
    end
  end

  always_comb begin
    state_d     = state_q;
    st_d        = st_q;
    rnd_d       = rnd_q;
    rk_idx_d    = rk_idx_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          st_d       = bus.in_data ^ bus.rk_data;
          rnd_d      = 4'(NR - 1);
          rk_idx_d   = 4'(NR - 1);
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
          state_d    = ROUND;
        end
      end
      ROUND: begin
        if (rnd_q != 4'd0) begin
          st_d     = mixed;
          rnd_d    = rnd_q - 4'd1;
          rk_idx_d = rnd_q - 4'd1;
        end else begin
          // Final round skips InvMixColumns.
          st_d        = t;
          rk_idx_d    = 4'd0;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          busy_d      = 1'b0;
          rk_idx_d    = 4'(NR);
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        rk_idx_d    = 4'(NR);
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      st_q        <= '0;
      rnd_q       <= 4'd0;
      rk_idx_q    <= 4'(NR);
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      st_q        <= st_d;
      rnd_q       <= rnd_d;
      rk_idx_q    <= rk_idx_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.rk_idx    = rk_idx_q;
  assign bus.out_data  = st_q;
endmodule

// File: tb/tb_aes_inv_round_ctrl.sv
// Bench for aes_inv_round_ctrl: known-answer table, corner-case sequences and random blocks
// checked against a byte-matrix AES-128 inverse cipher with a derived S-box and key schedule.
module tb_aes_inv_round_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  aes_inv_round_ctrl_if bus();

  aes_inv_round_ctrl #(.NR(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [7:0]   sbox  [256];
  logic [7:0]   isbox [256];
  logic [127:0] rk_tab [11];

  always_comb bus.rk_data = (bus.rk_idx <= 4'd10) ? rk_tab[bus.rk_idx] : '0;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // Forward S-box from brute-force inverse plus affine map; inverse table by inversion.
  task automatic init_sbox();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sbox[x]  = s;
      isbox[s] = 8'(x);
    end
  endtask

  task automatic set_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox[tmp[31:24]], sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]]} ^ {rc, 24'h0};
        rc  = xtime(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 11; r++) rk_tab[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [7:0] byte_of(input logic [127:0] v, input int k);
    return v[127-8*k -: 8];
  endfunction

  // Reference inverse cipher on a [row][col] byte matrix.
  function automatic logic [127:0] aes_dec(input logic [127:0] ct);
    logic [7:0]   s [4][4];
    logic [7:0]   n [4][4];
    logic [7:0]   m [4];
    logic [7:0]   tb;
    logic [127:0] res;
    m[0] = 8'h0e; m[1] = 8'h0b; m[2] = 8'h0d; m[3] = 8'h09;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        s[r][c] = byte_of(ct, 4*c+r) ^ byte_of(rk_tab[10], 4*c+r);
    for (int round = 9; round >= 0; round--) begin
      for (int r = 0; r < 4; r++)
        for (int k = 0; k < r; k++) begin
          tb = s[r][3]; s[r][3] = s[r][2]; s[r][2] = s[r][1]; s[r][1] = s[r][0]; s[r][0] = tb;
        end
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          s[r][c] = isbox[s[r][c]] ^ byte_of(rk_tab[round], 4*c+r);
      if (round != 0) begin
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 4; c++) begin
            n[r][c] = 8'h00;
            for (int k = 0; k < 4; k++) n[r][c] ^= gf_mul(m[(k-r+4)%4], s[k][c]);
          end
        s = n;
      end
    end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        res[127-8*(4*c+r) -: 8] = s[r][c];
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Called just after a negedge in IDLE; returns just after the accepting edge.
  task automatic accept(input logic [127:0] ct);
    check("idle_ctl", {bus.in_ready, bus.out_valid, bus.busy, bus.rk_idx}, {1'b1, 1'b0, 1'b0, 4'd10});
    bus.in_valid = 1'b1;
    bus.in_data  = ct;
    @(negedge clk);
  endtask

  // Runs rounds, optional backpressure and the output handshake; nv/nd drive the input meanwhile.
  task automatic complete(input logic [127:0] exp, input int bp, input logic nv, input logic [127:0] nd);
    bus.in_valid  = nv;
    bus.in_data   = nd;
    bus.out_ready = (bp == 0);
    for (int k = 9; k >= 0; k--) begin
      check("round_ctl", {bus.busy, bus.in_ready, bus.out_valid, bus.rk_idx}, {1'b1, 1'b0, 1'b0, 4'(k)});
      @(negedge clk);
    end
    check("done_ctl", {bus.out_valid, bus.in_ready, bus.busy, bus.rk_idx}, {1'b1, 1'b0, 1'b1, 4'd0});
    check("plaintext", bus.out_data, exp);
    for (int j = 0; j < bp; j++) begin
      @(negedge clk);
      check("hold_ctl", {bus.out_valid, bus.in_ready, bus.rk_idx}, {1'b1, 1'b0, 4'd0});
      check("hold_data", bus.out_data, exp);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("back_idle", {bus.out_valid, bus.in_ready, bus.busy, bus.rk_idx}, {1'b0, 1'b1, 1'b0, 4'd10});
  endtask

  typedef struct {
    logic [127:0] key;
    logic [127:0] ct;
    logic [127:0] pt;
    int           bp;
  } vec_t;

  localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] P1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] C2  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] P2  = 128'h3243f6a8885a308d313198a2e0370734;

  initial begin
    vec_t vecs [4];
    logic [127:0] key, ct, exp;
    int ov_seen;

    vecs[0] = '{K1, C1, P1, 0};
    vecs[1] = '{K1, C1, P1, 5};
    vecs[2] = '{K2, C2, P2, 2};
    vecs[3] = '{128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 128'h0, 1};

    rst_n         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    init_sbox();
    set_key(K1);

    // Power-up reset held for 3 cycles.
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_hold_ctl", {bus.in_ready, bus.out_valid, bus.busy, bus.rk_idx}, {1'b1, 1'b0, 1'b0, 4'd10});
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ctl", {bus.in_ready, bus.out_valid, bus.busy, bus.rk_idx}, {1'b1, 1'b0, 1'b0, 4'd10});
    check("rst_data", bus.out_data, 128'h0);

    for (int i = 0; i < 4; i++) begin
      set_key(vecs[i].key);
      accept(vecs[i].ct);
      complete(vecs[i].pt, vecs[i].bp, 1'b0, rand128());
    end

    // Input offered continuously while busy: zero block taken only after the handshake.
    set_key(K1);
    accept(C1);
    complete(P1, 0, 1'b1, 128'h0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    complete(aes_dec(128'h0), 0, 1'b0, rand128());

    // Back-to-back blocks under different keys, 12 cycles apart.
    set_key(K2);
    accept(C2);
    complete(P2, 0, 1'b1, C1);
    set_key(K1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    complete(P1, 0, 1'b0, rand128());

    // Reset pulse mid-block at round key 5.
    accept(C1);
    bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_rst_idx", {4'h0, bus.rk_idx}, {4'h0, 4'd5});
    rst_n = 1'b0;
    #1;
    check("async_rst_ctl", {bus.in_ready, bus.out_valid, bus.busy, bus.rk_idx}, {1'b1, 1'b0, 1'b0, 4'd10});
    check("async_rst_data", bus.out_data, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    ov_seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus.out_valid) ov_seen++;
    end
    check("no_out_after_rst", 128'(ov_seen), 128'h0);
    accept(C1);
    complete(P1, 0, 1'b0, rand128());

    // Random keys, blocks and backpressure against the reference model.
    for (int i = 0; i < 20; i++) begin
      key = rand128();
      ct  = rand128();
      set_key(key);
      exp = aes_dec(ct);
      accept(ct);
      complete(exp, int'($urandom_range(0, 3)), 1'b0, rand128());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
